// File: rtl/scale_cfg_sync_ctrl.sv
// Configuration controller for the nearest-neighbour scaler.
//
// It samples four image-size words that arrive through per-bit synchronisers.
// A set is accepted only after it has read identically for C_STABLE_CNT cycles.
// Accepted sets are rejected with a one-cycle cfg_err pulse when a destination
// size is zero. Otherwise the block computes the horizontal and vertical
// fixed-point step factors with one shared restoring divider, producing one
// quotient bit per cycle. The new set and its steps are committed atomically
// on the next rising edge of per_frame_vsync.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   src_width/height           synchronised source size
//   dst_width/height           synchronised destination size
//   per_frame_vsync            frame sync of the scaler input, active-high
//   cfg_src_w/h, cfg_dst_w/h   committed sizes
//   h_step, v_step             committed (src << C_FRAC_WIDTH) / dst
//   cfg_valid                  a configuration has been committed
//   cfg_update                 one-cycle pulse on the commit cycle
//   cfg_err                    one-cycle pulse when a stable set is rejected
//   busy                       dividing or waiting for frame start
module scale_cfg_sync_ctrl #(
  parameter int unsigned C_DATA_WIDTH = 12,
  parameter int unsigned C_FRAC_WIDTH = 16,
  parameter int unsigned C_STABLE_CNT = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [C_DATA_WIDTH-1:0]              src_width,
  input  logic [C_DATA_WIDTH-1:0]              src_height,
  input  logic [C_DATA_WIDTH-1:0]              dst_width,
  input  logic [C_DATA_WIDTH-1:0]              dst_height,
  input  logic                                 per_frame_vsync,
  output logic [C_DATA_WIDTH-1:0]              cfg_src_w,
  output logic [C_DATA_WIDTH-1:0]              cfg_src_h,
  output logic [C_DATA_WIDTH-1:0]              cfg_dst_w,
  output logic [C_DATA_WIDTH-1:0]              cfg_dst_h,
  output logic [C_DATA_WIDTH+C_FRAC_WIDTH-1:0] h_step,
  output logic [C_DATA_WIDTH+C_FRAC_WIDTH-1:0] v_step,
  output logic                                 cfg_valid,
  output logic                                 cfg_update,
  output logic                                 cfg_err,
  output logic                                 busy
);

  localparam int unsigned W    = C_DATA_WIDTH;
  localparam int unsigned Q    = C_DATA_WIDTH + C_FRAC_WIDTH;
  localparam int unsigned SetW = 4 * W;
  localparam int unsigned CntW = $clog2(Q);

  typedef enum logic [2:0] {StIdle, StDivH, StDivV, StWaitFrame, StCommit} state_e;

  state_e state_q, state_d;

  logic [SetW-1:0] in_set, sample_q, pend_q, cfg_set_q;
  logic [3:0]      stab_cnt_q;
  logic            vsync_q, err_lock_q, cfg_valid_q;
  logic [Q-1:0]    h_step_q, v_step_q, pend_h_q, pend_h_d, pend_v_q, pend_v_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [Q-1:0]    quo_q, quo_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;

  logic in_change, stable, vs_rise, set_zero, want_new;
  logic start_div, err_fire, load_cfg;

  assign in_set    = {src_width, src_height, dst_width, dst_height};
  assign in_change = (in_set != sample_q);
  assign stable    = (stab_cnt_q == 4'(C_STABLE_CNT));
  assign vs_rise   = per_frame_vsync & ~vsync_q;

  // Decisions use the registered sample, which equals the live input whenever in_change is low.
  assign set_zero  = (sample_q[2*W-1:W] == '0) || (sample_q[W-1:0] == '0);
  assign want_new  = stable && !in_change && !err_lock_q &&
                     (!cfg_valid_q || (sample_q != cfg_set_q));

  // Shared restoring divider step.
  logic [W-1:0] divisor, rem_next, rem_sub;
  logic [W:0]   trial;
  logic         trial_ge;
  logic [Q-1:0] quo_next;
  logic         div_last;

  assign divisor  = (state_q == StDivV) ? pend_q[W-1:0] : pend_q[2*W-1:W];
  assign trial    = {rem_q, quo_q[Q-1]};
  assign trial_ge = (trial >= {1'b0, divisor});
  // When trial >= divisor, the difference is below the divisor, so W bits suffice.
  assign rem_sub  = trial[W-1:0] - divisor;
  assign rem_next = trial_ge ? rem_sub : trial[W-1:0];
  assign quo_next = {quo_q[Q-2:0], trial_ge};
  assign div_last = (bit_cnt_q == CntW'(Q - 1));

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. An input change aborts any pending work.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (want_new && !set_zero) state_d = StDivH;
      end
      StDivH: begin
        if (in_change)     state_d = StIdle;
        else if (div_last) state_d = StDivV;
      end
      StDivV: begin
        if (in_change)     state_d = StIdle;
        else if (div_last) state_d = StWaitFrame;
      end
      StWaitFrame: begin
        if (in_change)    state_d = StIdle;
        else if (vs_rise) state_d = StCommit;
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM: outputs and datapath strobes.
  always_comb begin
    start_div  = 1'b0;
    err_fire   = 1'b0;
    busy       = 1'b0;
    cfg_update = 1'b0;
    load_cfg   = 1'b0;
    unique case (state_q)
      StIdle: begin
        start_div = want_new && !set_zero;
        err_fire  = want_new && set_zero;
      end
      StDivH, StDivV: busy = 1'b1;
      StWaitFrame: begin
        busy     = 1'b1;
        load_cfg = !in_change && vs_rise;
      end
      StCommit: cfg_update = 1'b1;
      default: ;
    endcase
  end

  // Divider next state.
  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    bit_cnt_d = bit_cnt_q;
    pend_h_d  = pend_h_q;
    pend_v_d  = pend_v_q;
    if (start_div) begin
      quo_d     = {sample_q[4*W-1:3*W], {C_FRAC_WIDTH{1'b0}}};
      rem_d     = '0;
      bit_cnt_d = '0;
    end else if (state_q == StDivH || state_q == StDivV) begin
      quo_d     = quo_next;
      rem_d     = rem_next;
      bit_cnt_d = bit_cnt_q + CntW'(1);
      if (div_last) begin
        rem_d     = '0;
        bit_cnt_d = '0;
        if (state_q == StDivH) begin
          pend_h_d = quo_next;
          quo_d    = {pend_q[3*W-1:2*W], {C_FRAC_WIDTH{1'b0}}};
        end else begin
          pend_v_d = quo_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q    <= '0;
      stab_cnt_q  <= '0;
      vsync_q     <= 1'b0;
      err_lock_q  <= 1'b0;
      pend_q      <= '0;
      pend_h_q    <= '0;
      pend_v_q    <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      bit_cnt_q   <= '0;
      cfg_set_q   <= '0;
      h_step_q    <= '0;
      v_step_q    <= '0;
      cfg_valid_q <= 1'b0;
    end else begin
      sample_q <= in_set;
      vsync_q  <= per_frame_vsync;
      if (in_change) begin
        stab_cnt_q <= '0;
      end else if (!stable) begin
        stab_cnt_q <= stab_cnt_q + 4'd1;
      end
      // A rejected set is not retried until the input moves.
      if (in_change) begin
        err_lock_q <= 1'b0;
      end else if (err_fire) begin
        err_lock_q <= 1'b1;
      end
      if (start_div) pend_q <= sample_q;
      pend_h_q  <= pend_h_d;
      pend_v_q  <= pend_v_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      bit_cnt_q <= bit_cnt_d;
      // Load on entry to the commit cycle so cfg_update and the new values coincide.
      if (load_cfg) begin
        cfg_set_q   <= pend_q;
        h_step_q    <= pend_h_q;
        v_step_q    <= pend_v_q;
        cfg_valid_q <= 1'b1;
      end
    end
  end

  assign cfg_src_w = cfg_set_q[4*W-1:3*W];
  assign cfg_src_h = cfg_set_q[3*W-1:2*W];
  assign cfg_dst_w = cfg_set_q[2*W-1:W];
  assign cfg_dst_h = cfg_set_q[W-1:0];
  assign h_step    = h_step_q;
  assign v_step    = v_step_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_err   = err_fire;

endmodule

// File: tb/tb_scale_cfg_sync_ctrl.sv
module tb_scale_cfg_sync_ctrl;

  localparam int W    = 12;
  localparam int F    = 16;
  localparam int QW   = W + F;
  localparam int Q    = QW;
  localparam int CfgW = 4 * W + 2 * QW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  sw = '0, sh = '0, dw = '0, dh = '0;
  logic          vs_gen = 1'b0, vs_man = 1'b0, vs_auto = 1'b0;
  logic          vsync;
  logic [W-1:0]  cfg_src_w, cfg_src_h, cfg_dst_w, cfg_dst_h;
  logic [QW-1:0] h_step, v_step;
  logic          cfg_valid, cfg_update, cfg_err, busy;

  assign vsync = vs_auto ? vs_gen : vs_man;

  scale_cfg_sync_ctrl #(
    .C_DATA_WIDTH(W),
    .C_FRAC_WIDTH(F),
    .C_STABLE_CNT(4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .src_width      (sw),
    .src_height     (sh),
    .dst_width      (dw),
    .dst_height     (dh),
    .per_frame_vsync(vsync),
    .cfg_src_w      (cfg_src_w),
    .cfg_src_h      (cfg_src_h),
    .cfg_dst_w      (cfg_dst_w),
    .cfg_dst_h      (cfg_dst_h),
    .h_step         (h_step),
    .v_step         (v_step),
    .cfg_valid      (cfg_valid),
    .cfg_update     (cfg_update),
    .cfg_err        (cfg_err),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Free-running frame sync: a short pulse every 200 cycles.
  initial begin
    forever begin
      repeat (196) @(posedge clk);
      #1 vs_gen = 1'b1;
      repeat (4) @(posedge clk);
      #1 vs_gen = 1'b0;
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model: the configuration the scaler should currently see.
  int unsigned m_sw, m_sh, m_dw, m_dh;
  bit          m_valid = 1'b0;

  function automatic logic [QW-1:0] ref_step(int unsigned s, int unsigned d);
    longint num;
    num = longint'(s) * 65536;
    return QW'(num / longint'(d));
  endfunction

  function automatic logic [CfgW-1:0] exp_cfg();
    if (!m_valid) return '0;
    return {W'(m_sw), W'(m_sh), W'(m_dw), W'(m_dh), ref_step(m_sw, m_dw), ref_step(m_sh, m_dh)};
  endfunction

  logic [CfgW-1:0] obs_cfg, prev_cfg;
  assign obs_cfg = {cfg_src_w, cfg_src_h, cfg_dst_w, cfg_dst_h, h_step, v_step};

  // Event counters; outputs may only move while cfg_update is high.
  int upd_cnt = 0, err_cnt = 0, busy_cyc = 0, bad_change = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cfg <= obs_cfg;
    end else begin
      if (cfg_update === 1'b1) upd_cnt <= upd_cnt + 1;
      if (cfg_err === 1'b1) err_cnt <= err_cnt + 1;
      if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
      if (obs_cfg !== prev_cfg && cfg_update !== 1'b1) bad_change <= bad_change + 1;
      prev_cfg <= obs_cfg;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(int unsigned a, int unsigned b, int unsigned c, int unsigned d);
    @(posedge clk);
    #1;
    sw = W'(a); sh = W'(b); dw = W'(c); dh = W'(d);
  endtask

  task automatic raise_vs();
    @(posedge clk);
    #1 vs_man = 1'b1;
  endtask

  task automatic lower_vs();
    @(posedge clk);
    #1 vs_man = 1'b0;
  endtask

  task automatic wait_update(int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cfg_update === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_busy(int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw = 12'd640; sh = 12'd480; dw = 12'd1280; dh = 12'd960;
    repeat (3) @(negedge clk);
    checks++;
    if ({obs_cfg, cfg_valid, cfg_update, cfg_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got cfg=%h valid=%b upd=%b err=%b busy=%b, want all 0",
               obs_cfg, cfg_valid, cfg_update, cfg_err, busy);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit got;
    m_sw = 640; m_sh = 480; m_dw = 1280; m_dh = 960; m_valid = 1'b1;
    vs_auto = 1'b1;
    wait_update(600, got);
    checks++;
    if (got !== 1'b1) begin
      errors++; $display("FAIL basic_update: got no cfg_update, want one within 600 cycles");
    end
    checks++;
    if (obs_cfg !== exp_cfg()) begin
      errors++; $display("FAIL basic_cfg: got %h want %h", obs_cfg, exp_cfg());
    end
    checks++;
    if ({h_step, v_step} !== {28'h8000, 28'h8000}) begin
      errors++; $display("FAIL basic_steps: got h=%h v=%h want 8000/8000", h_step, v_step);
    end
    checks++;
    if (cfg_valid !== 1'b1) begin
      errors++; $display("FAIL basic_valid: got %b want 1", cfg_valid);
    end
    @(negedge clk);
    checks++;
    if (cfg_update !== 1'b0) begin
      errors++; $display("FAIL basic_pulse_width: got cfg_update=%b want 0", cfg_update);
    end
    tick(250);
    vs_auto = 1'b0;
    checks++;
    if (upd_cnt !== 1) begin
      errors++; $display("FAIL basic_update_count: got %0d want 1", upd_cnt);
    end
  endtask

  task automatic test_frame_commit();
    bit got;
    int upd0;
    upd0 = upd_cnt;
    drive(1920, 1080, 1280, 720);
    wait_busy(20, got);
    checks++;
    if (got !== 1'b1) begin
      errors++; $display("FAIL frame_busy: got no busy, want busy within 20 cycles");
    end
    // A frame edge during the divide must be ignored.
    raise_vs();
    tick(2);
    lower_vs();
    tick(80);
    checks++;
    if (obs_cfg !== exp_cfg() || upd_cnt !== upd0) begin
      errors++;
      $display("FAIL frame_hold: got cfg=%h updates=%0d want cfg=%h updates=%0d",
               obs_cfg, upd_cnt - upd0, exp_cfg(), 0);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL frame_wait_busy: got %b want 1", busy);
    end
    m_sw = 1920; m_sh = 1080; m_dw = 1280; m_dh = 720;
    raise_vs();
    wait_update(10, got);
    checks++;
    if (got !== 1'b1) begin
      errors++; $display("FAIL frame_update: got no cfg_update, want one after vsync");
    end
    checks++;
    if ({h_step, v_step} !== {28'h18000, 28'h18000} || obs_cfg !== exp_cfg()) begin
      errors++; $display("FAIL frame_cfg: got %h want %h", obs_cfg, exp_cfg());
    end
    lower_vs();
  endtask

  task automatic test_toggle();
    bit got;
    int upd0, busy0;
    int unsigned a, b, c, d;
    a = $urandom_range(2, 4095); b = $urandom_range(1, 4095);
    c = $urandom_range(1, 1000); d = $urandom_range(1, 4095);
    upd0 = upd_cnt; busy0 = busy_cyc;
    for (int i = 0; i < 10; i++) begin
      drive(a ^ (i % 2), b, c, d);
      tick(2);
    end
    checks++;
    if (busy_cyc !== busy0) begin
      errors++; $display("FAIL toggle_no_div: got %0d busy cycles want 0", busy_cyc - busy0);
    end
    drive(a, b, c, d);
    m_sw = a; m_sh = b; m_dw = c; m_dh = d;
    tick(80);
    raise_vs();
    wait_update(10, got);
    checks++;
    if (got !== 1'b1) begin
      errors++; $display("FAIL toggle_update: got no cfg_update, want one after settle");
    end
    checks++;
    if (obs_cfg !== exp_cfg()) begin
      errors++; $display("FAIL toggle_cfg: got %h want %h", obs_cfg, exp_cfg());
    end
    lower_vs();
    tick(3);
    checks++;
    if (upd_cnt - upd0 !== 1) begin
      errors++; $display("FAIL toggle_count: got %0d updates want 1", upd_cnt - upd0);
    end
  endtask

  task automatic test_abort();
    bit got;
    int upd0;
    int unsigned a, b, c, d, c2;
    a = $urandom_range(1, 4095); b = $urandom_range(1, 4095);
    c = $urandom_range(1, 4095); d = $urandom_range(1, 4095);
    c2 = $urandom_range(1, 4095);
    while (c2 == c) c2 = $urandom_range(1, 4095);
    upd0 = upd_cnt;
    drive(a, b, c, d);
    wait_busy(20, got);
    checks++;
    if (got !== 1'b1) begin
      errors++; $display("FAIL abort_busy: got no busy, want busy within 20 cycles");
    end
    tick(Q + 5);
    drive(a, b, c2, d);
    tick(1);
    checks++;
    if (busy !== 1'b0 || obs_cfg !== exp_cfg()) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b cfg=%h want busy=0 cfg=%h", busy, obs_cfg, exp_cfg());
    end
    m_sw = a; m_sh = b; m_dw = c2; m_dh = d;
    tick(80);
    checks++;
    if (upd_cnt !== upd0) begin
      errors++; $display("FAIL abort_no_update: got %0d updates want 0", upd_cnt - upd0);
    end
    raise_vs();
    wait_update(10, got);
    checks++;
    if (got !== 1'b1 || obs_cfg !== exp_cfg()) begin
      errors++; $display("FAIL abort_recommit: got upd=%b cfg=%h want upd=1 cfg=%h",
                         got, obs_cfg, exp_cfg());
    end
    lower_vs();
  endtask

  task automatic test_zero();
    int upd0, err0, busy0;
    upd0 = upd_cnt; err0 = err_cnt; busy0 = busy_cyc;
    drive($urandom_range(1, 4095), $urandom_range(1, 4095), $urandom_range(1, 4095), 0);
    tick(40);
    raise_vs();
    tick(2);
    lower_vs();
    tick(40);
    checks++;
    if (err_cnt - err0 !== 1) begin
      errors++; $display("FAIL zero_err: got %0d cfg_err pulses want 1", err_cnt - err0);
    end
    checks++;
    if (busy_cyc !== busy0 || upd_cnt !== upd0) begin
      errors++; $display("FAIL zero_idle: got busy cycles=%0d updates=%0d want 0/0",
                         busy_cyc - busy0, upd_cnt - upd0);
    end
    checks++;
    if (obs_cfg !== exp_cfg() || cfg_valid !== 1'b1) begin
      errors++; $display("FAIL zero_retain: got %h valid=%b want %h valid=1",
                         obs_cfg, cfg_valid, exp_cfg());
    end
  endtask

  task automatic test_reset_wait();
    bit got;
    int unsigned a, b, c, d;
    a = $urandom_range(1, 4095); b = $urandom_range(1, 4095);
    c = $urandom_range(1, 4095); d = $urandom_range(1, 4095);
    drive(a, b, c, d);
    tick(80);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rstwait_busy: got %b want 1", busy);
    end
    rst_n = 1'b0;
    m_valid = 1'b0;
    #2;
    checks++;
    if ({obs_cfg, cfg_valid, cfg_update, cfg_err, busy} !== '0) begin
      errors++; $display("FAIL rstwait_clear: got cfg=%h valid=%b busy=%b want all 0",
                         obs_cfg, cfg_valid, busy);
    end
    tick(2);
    rst_n = 1'b1;
    m_sw = a; m_sh = b; m_dw = c; m_dh = d; m_valid = 1'b1;
    tick(80);
    raise_vs();
    wait_update(10, got);
    checks++;
    if (got !== 1'b1 || obs_cfg !== exp_cfg() || cfg_valid !== 1'b1) begin
      errors++; $display("FAIL rstwait_recommit: got upd=%b cfg=%h valid=%b want 1/%h/1",
                         got, obs_cfg, cfg_valid, exp_cfg());
    end
    lower_vs();
  endtask

  task automatic test_back_to_back();
    bit got;
    int unsigned a, b, c, d;
    for (int k = 0; k < 4; k++) begin
      a = $urandom_range(1, 4095); b = $urandom_range(1, 4095);
      c = $urandom_range(1, 4095); d = $urandom_range(1, 4095);
      drive(a, b, c, d);
      m_sw = a; m_sh = b; m_dw = c; m_dh = d;
      tick(80);
      raise_vs();
      wait_update(10, got);
      checks++;
      if (got !== 1'b1 || obs_cfg !== exp_cfg()) begin
        errors++; $display("FAIL b2b_%0d: got upd=%b cfg=%h want upd=1 cfg=%h",
                           k, got, obs_cfg, exp_cfg());
      end
      lower_vs();
    end
    tick(2);
    checks++;
    if (bad_change !== 0) begin
      errors++; $display("FAIL stray_change: got %0d output changes without cfg_update want 0",
                         bad_change);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame_commit();
    test_toggle();
    test_abort();
    test_zero();
    test_reset_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
